// File: rtl/prog_counter_tick.sv
// Programmable up/down/bounce/hold counter stepped by an in-domain prescaler tick.
// Counts, tick and terminal-count pulses are all registered for direct LED/ILA use.
module prog_counter_tick #(
  parameter int WIDTH   = 8,
  parameter int DIV     = 5000000,
  parameter int MOD_MAX = 255
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             dir
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]    LAST = DW'(DIV - 1);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    UP     = 2'b00,
    DOWN   = 2'b01,
    BOUNCE = 2'b10,
    HOLD   = 2'b11
  } mode_t;

  logic [DW-1:0]    div_cnt;
  logic             step;
  logic [WIDTH-1:0] clamp;
  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_dir;
  logic             nxt_tc;

  // A step happens on the prescaler wrap edge only.
  assign step  = en && (div_cnt == LAST);
  assign clamp = (load_val > TOP) ? TOP : load_val;

  // Prescaler: free-runs while enabled, tick marks its wrap.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      if (step) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Next count/direction/terminal flag for a step in the current mode.
  always_comb begin
    nxt_cnt = count;
    nxt_dir = dir;
    nxt_tc  = 1'b0;
    unique case (mode_t'(mode))
      UP: begin
        nxt_dir = 1'b1;
        if (count == TOP) begin
          nxt_cnt = '0;
          nxt_tc  = 1'b1;
        end else begin
          nxt_cnt = count + ONE;
        end
      end
      DOWN: begin
        nxt_dir = 1'b0;
        if (count == '0) begin
          nxt_cnt = TOP;
          nxt_tc  = 1'b1;
        end else begin
          nxt_cnt = count - ONE;
        end
      end
      BOUNCE: begin
        if (dir) begin
          if (count == TOP) begin
            nxt_cnt = TOP - ONE;
            nxt_dir = 1'b0;
            nxt_tc  = 1'b1;
          end else begin
            nxt_cnt = count + ONE;
          end
        end else begin
          if (count == '0) begin
            nxt_cnt = ONE;
            nxt_dir = 1'b1;
            nxt_tc  = 1'b1;
          end else begin
            nxt_cnt = count - ONE;
          end
        end
      end
      HOLD: begin
        nxt_cnt = count;
      end
      default: begin
        nxt_cnt = count;
      end
    endcase
  end

  // Count state: load beats stepping; tc only on a terminal step.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count <= '0;
      dir   <= 1'b1;
      tc    <= 1'b0;
    end else if (load) begin
      count <= clamp;
      tc    <= 1'b0;
    end else if (step) begin
      count <= nxt_cnt;
      dir   <= nxt_dir;
      tc    <= nxt_tc;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
